// File: rtl/jtag_sim_pkg.sv
// jtag_sim_pkg: shared constants and output-stage states for the JTAG sim FIFOs
package jtag_sim_pkg;
  localparam int DATA_W = 8;
  localparam int DEF_DEPTH = 64;
  typedef enum logic {IDLE, HOLD} tx_state_t;
endpackage

// File: rtl/jtag_sim_fifo_mem.sv
// jtag_sim_fifo_mem: FIFO storage with write/read pointers that wrap naturally
module jtag_sim_fifo_mem import jtag_sim_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  // pointers advance on each accepted write / pop, wrapping at the power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end
  // storage is deliberately not reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wr_ptr] <= i_wdata;
  end
  assign o_rdata = r_mem[r_rd_ptr];
endmodule

// File: rtl/jtag_sim_scfifo_w.sv
// jtag_sim_scfifo_w: host write FIFO drained at a paced rate into a valid/ready byte sink
module jtag_sim_scfifo_w import jtag_sim_pkg::*; #(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DRAIN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_wr,
  input  logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_FF,
  output logic              wfifo_empty,
  output logic [5:0]        wfifo_used,
  output logic              wr_ovf,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready
);
  localparam int PW = DRAIN_DIV > 1 ? $clog2(DRAIN_DIV) : 1;
  logic [6:0]        r_count;
  logic [PW-1:0]     r_pace;
  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] w_rdata;
  logic              r_ovf;
  logic              w_tick;
  logic              w_wr;
  logic              w_pop;
  assign fifo_FF     = r_count == 7'(DEPTH);
  assign wfifo_empty = r_count == 7'd0;
  assign wfifo_used  = r_count[5:0];
  assign w_tick      = r_pace == '0;
  assign w_wr        = rst_n & fifo_wr & ~fifo_FF;
  assign w_pop       = rst_n & (r_state == IDLE) & w_tick & ~wfifo_empty;
  assign tx_data     = r_tx_data;
  assign wr_ovf      = r_ovf;
  jtag_sim_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_wr),
    .i_wdata (fifo_wdata),
    .i_rd    (w_pop),
    .o_rdata (w_rdata)
  );
  // occupancy excludes the byte parked in the output stage
  always_ff @(posedge clk) begin
    if (!rst_n) r_count <= '0;
    else r_count <= r_count + 7'(w_wr) - 7'(w_pop);
  end
  // pace counter: tick when it reaches zero, then reload
  always_ff @(posedge clk) begin
    if (!rst_n) r_pace <= PW'(DRAIN_DIV - 1);
    else r_pace <= w_tick ? PW'(DRAIN_DIV - 1) : r_pace - PW'(1);
  end
  // output stage state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // pop moves IDLE->HOLD; handshake returns to IDLE
  always_comb begin
    w_state_nxt = (r_state == IDLE) ? (w_pop ? HOLD : IDLE) : (tx_ready ? IDLE : HOLD);
  end
  // valid is simply being in HOLD
  always_comb begin
    tx_valid = (r_state == HOLD);
  end
  // output byte loads only on pop, so it is stable throughout HOLD
  always_ff @(posedge clk) begin
    if (!rst_n) r_tx_data <= '0;
    else if (w_pop) r_tx_data <= w_rdata;
  end
  // sticky overflow on any write attempted while full
  always_ff @(posedge clk) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (fifo_wr && fifo_FF) r_ovf <= 1'b1;
  end
endmodule

// File: tb/tb_jtag_sim_scfifo_w.sv
// tb_jtag_sim_scfifo_w: randomized checks of two configurations against a queue model
module tb_jtag_sim_scfifo_w;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_wr = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] fifo_wdata = 8'h00;
  logic       ff [2];
  logic       em [2];
  logic       ov [2];
  logic       tv [2];
  logic [5:0] us [2];
  logic [7:0] td [2];
  int md  [2] = '{4, 1};
  int mdp [2] = '{64, 16};
  logic [7:0] mbuf [2][256];
  int   mhead [2];
  int   mcnt  [2];
  int   mn    [2];
  logic mhold [2];
  logic movf  [2];
  logic [7:0] mheld [2];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  jtag_sim_scfifo_w #(.DEPTH(64), .DRAIN_DIV(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .fifo_FF(ff[0]), .wfifo_empty(em[0]), .wfifo_used(us[0]), .wr_ovf(ov[0]),
    .tx_valid(tv[0]), .tx_data(td[0]), .tx_ready(tx_ready));
  jtag_sim_scfifo_w #(.DEPTH(16), .DRAIN_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .fifo_FF(ff[1]), .wfifo_empty(em[1]), .wfifo_used(us[1]), .wr_ovf(ov[1]),
    .tx_valid(tv[1]), .tx_data(td[1]), .tx_ready(tx_ready));

  task automatic step(input logic wr, input logic [7:0] d, input logic rdy);
    fifo_wr = wr;
    fifo_wdata = d;
    tx_ready = rdy;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      bit full, tick, pop, hs;
      if (!rst_n) begin
        mhead[i] = 0; mcnt[i] = 0; mn[i] = 0;
        mhold[i] = 1'b0; movf[i] = 1'b0; mheld[i] = 8'h00;
      end else begin
        full = (mcnt[i] == mdp[i]);
        tick = ((mn[i] % md[i]) == md[i] - 1);
        pop  = !mhold[i] && tick && mcnt[i] > 0;
        hs   = mhold[i] && rdy;
        if (wr && full) movf[i] = 1'b1;
        if (pop) begin
          mheld[i] = mbuf[i][mhead[i]];
          mhead[i] = (mhead[i] + 1) % 256;
          mcnt[i]--;
          mhold[i] = 1'b1;
        end else if (hs) mhold[i] = 1'b0;
        if (wr && !full) begin
          mbuf[i][(mhead[i] + mcnt[i]) % 256] = d;
          mcnt[i]++;
        end
        mn[i]++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFE, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      vecs++; if (tv[i] !== 1'b0) begin errs++; $display("FAIL reset_tx_valid[%0d] got %b exp 0", i, tv[i]); end
      vecs++; if (td[i] !== 8'h00) begin errs++; $display("FAIL reset_tx_data[%0d] got %h exp 00", i, td[i]); end
      vecs++; if (ff[i] !== 1'b0) begin errs++; $display("FAIL reset_full[%0d] got %b exp 0", i, ff[i]); end
      vecs++; if (em[i] !== 1'b1) begin errs++; $display("FAIL reset_empty[%0d] got %b exp 1", i, em[i]); end
      vecs++; if (us[i] !== 6'd0) begin errs++; $display("FAIL reset_used[%0d] got %0d exp 0", i, us[i]); end
      vecs++; if (ov[i] !== 1'b0) begin errs++; $display("FAIL reset_ovf[%0d] got %b exp 0", i, ov[i]); end
    end
  endtask

  task automatic test_single();
    int pulses [2];
    logic [7:0] seen [2];
    do_reset();
    pulses = '{0, 0};
    seen = '{8'h00, 8'h00};
    step(1'b1, 8'hA5, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 2; i++) if (tv[i]) begin pulses[i]++; seen[i] = td[i]; end
    end
    for (int i = 0; i < 2; i++) begin
      vecs++; if (pulses[i] !== 1) begin errs++; $display("FAIL single_pulses[%0d] got %0d exp 1", i, pulses[i]); end
      vecs++; if (seen[i] !== 8'hA5) begin errs++; $display("FAIL single_data[%0d] got %h exp a5", i, seen[i]); end
      vecs++; if (em[i] !== 1'b1) begin errs++; $display("FAIL single_empty[%0d] got %b exp 1", i, em[i]); end
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 65; k++) step(1'b1, 8'(k), 1'b0);
    vecs++; if (ff[0] !== 1'b1) begin errs++; $display("FAIL fill_full got %b exp 1", ff[0]); end
    vecs++; if (us[0] !== 6'd0) begin errs++; $display("FAIL fill_used got %0d exp 0", us[0]); end
    vecs++; if (ov[0] !== 1'b0) begin errs++; $display("FAIL fill_ovf_early got %b exp 0", ov[0]); end
    vecs++; if (tv[0] !== 1'b1 || td[0] !== 8'h00) begin errs++; $display("FAIL fill_hold got v=%b d=%h exp v=1 d=00", tv[0], td[0]); end
    vecs++; if (ff[1] !== 1'b1 || ov[1] !== 1'b1) begin errs++; $display("FAIL fill_small got ff=%b ovf=%b exp 1 1", ff[1], ov[1]); end
    step(1'b1, 8'hEE, 1'b0);
    vecs++; if (ov[0] !== 1'b1) begin errs++; $display("FAIL ovf_set got %b exp 1", ov[0]); end
    vecs++; if (ff[0] !== 1'b1 || us[0] !== 6'd0 || em[0] !== 1'b0) begin errs++; $display("FAIL ovf_count got ff=%b used=%0d em=%b exp 1 0 0", ff[0], us[0], em[0]); end
    vecs++; if (td[0] !== mheld[0] || us[1] !== 6'(mcnt[1])) begin errs++; $display("FAIL ovf_model got d=%h u1=%0d exp %h %0d", td[0], us[1], mheld[0], mcnt[1]); end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    int waited = 0;
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 8'($urandom), 1'b0);
    while (!tv[0] && waited < 10) begin step(1'b0, 8'h00, 1'b0); waited++; end
    vecs++; if (tv[0] !== 1'b1) begin errs++; $display("FAIL stall_valid_start got %b exp 1", tv[0]); end
    held = mheld[0];
    for (int c = 0; c < 20; c++) begin
      step(1'($urandom), 8'($urandom), 1'b0);
      vecs++; if (tv[0] !== 1'b1 || td[0] !== held) begin errs++; $display("FAIL stall_stable c=%0d got v=%b d=%h exp v=1 d=%h", c, tv[0], td[0], held); end
      vecs++; if (us[0] !== 6'(mcnt[0]) || ov[0] !== movf[0]) begin errs++; $display("FAIL stall_count c=%0d got %0d/%b exp %0d/%b", c, us[0], ov[0], mcnt[0], movf[0]); end
    end
    step(1'b0, 8'h00, 1'b1);
    vecs++; if (tv[0] !== 1'b0) begin errs++; $display("FAIL stall_handshake got %b exp 0", tv[0]); end
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 8'h00, 1'b0);
      vecs++; if (tv[0] !== mhold[0] || td[0] !== mheld[0] || us[0] !== 6'(mcnt[0])) begin errs++; $display("FAIL stall_after c=%0d got v=%b d=%h u=%0d exp %b %h %0d", c, tv[0], td[0], us[0], mhold[0], mheld[0], mcnt[0]); end
    end
  endtask

  task automatic test_stream();
    logic [7:0] exp_q [$];
    logic [7:0] e;
    logic wr, rdy;
    logic [7:0] d;
    int got = 0;
    do_reset();
    for (int c = 0; c < 700; c++) begin
      wr = 1'($urandom);
      d = 8'($urandom);
      rdy = ($urandom % 8) != 0;
      if (tv[1] && rdy) begin
        vecs++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL stream_extra c=%0d got %h exp none", c, td[1]); end
        else begin
          e = exp_q.pop_front();
          if (td[1] !== e) begin errs++; $display("FAIL stream_data c=%0d got %h exp %h", c, td[1], e); end
        end
        got++;
      end
      if (wr && mcnt[1] != mdp[1]) exp_q.push_back(d);
      step(wr, d, rdy);
      for (int i = 0; i < 2; i++) begin
        vecs++;
        if (tv[i] !== mhold[i] || td[i] !== mheld[i] || us[i] !== 6'(mcnt[i]) || ff[i] !== (mcnt[i] == mdp[i]) || em[i] !== (mcnt[i] == 0) || ov[i] !== movf[i])
          begin errs++; $display("FAIL stream_state[%0d] c=%0d got v=%b d=%h u=%0d f=%b e=%b o=%b exp %b %h %0d %b %b %b", i, c, tv[i], td[i], us[i], ff[i], em[i], ov[i], mhold[i], mheld[i], mcnt[i], mcnt[i] == mdp[i], mcnt[i] == 0, movf[i]); end
      end
    end
    vecs++; if (got <= 200) begin errs++; $display("FAIL stream_volume got %0d exp >200", got); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 12; k++) step(1'b1, 8'(k + 100), 1'b0);
    vecs++; if (tv[0] !== 1'b1 || us[0] < 6'd10) begin errs++; $display("FAIL mid_setup got v=%b u=%0d exp v=1 u>=10", tv[0], us[0]); end
    rst_n = 1'b0;
    step(1'b1, 8'h77, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vecs++; if (tv[i] !== 1'b0 || em[i] !== 1'b1 || ov[i] !== 1'b0 || us[i] !== 6'd0) begin errs++; $display("FAIL mid_reset[%0d] got v=%b e=%b o=%b u=%0d exp 0 1 0 0", i, tv[i], em[i], ov[i], us[i]); end
    end
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 8'h00, 1'b1);
      vecs++; if (tv[0] !== 1'b0 || tv[1] !== 1'b0) begin errs++; $display("FAIL mid_stale c=%0d got %b%b exp 00", c, tv[0], tv[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stall();
    test_stream();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
